// File: rtl/rand_seq_pkg.sv
// Shared types for the middle-square sequence generator: FSM state encoding
// and the all-zero substitution pattern used when the zero guard is built in.
package rand_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SQUARE,
    DONE
  } gen_fsm_t;

  localparam int MAX_WIDTH = 16;

  // Alternating 01 pattern (0x55 for an 8-bit state), sized by the caller.
  function automatic logic [MAX_WIDTH-1:0] zero_guard(input int width);
    logic [MAX_WIDTH-1:0] pattern;
    pattern = '0;
    for (int i = 0; i < MAX_WIDTH / 2; i++) begin
      if (i < width / 2) pattern[2*i] = 1'b1;
    end
    return pattern;
  endfunction

endpackage

// File: rtl/ms_square_mul.sv
// Sequential shift-add squarer: one multiplier bit per cycle, WIDTH cycles in
// total (bit 0 is folded into the start cycle), middle WIDTH bits presented.
module ms_square_mul #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             kill,
  input  logic [WIDTH-1:0] operand,
  output logic             done,
  output logic [WIDTH-1:0] mid_square
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               active;

  // done pulses on the edge that folds in the last multiplier bit; acc then
  // holds the full product until the next start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else if (kill) begin
      active <= 1'b0;
      done   <= 1'b0;
    end else if (start) begin
      acc    <= operand[0] ? {{WIDTH{1'b0}}, operand} : '0;
      mcand  <= {{(WIDTH-1){1'b0}}, operand, 1'b0};
      mplier <= operand >> 1;
      cnt    <= CW'(1);
      active <= 1'b1;
      done   <= 1'b0;
    end else if (active) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      done   <= (cnt == CW'(WIDTH - 1));
      active <= (cnt != CW'(WIDTH - 1));
    end else begin
      done <= 1'b0;
    end
  end

  assign mid_square = acc[WIDTH+WIDTH/2-1 : WIDTH/2];

endmodule

// File: rtl/rand_seq_gen.sv
// Middle-square random symbol generator with a small sequence buffer.
// Define RAND_SEQ_ZERO_GUARD_EN to replace an all-zero state with a fixed pattern.
module rand_seq_gen #(
  parameter int               WIDTH        = 8,
  parameter int               OUT_W        = 2,
  parameter int               DEPTH        = 32,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(8'hA7)
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       seed_load,
  input  logic [WIDTH-1:0]           seed,
  input  logic                       gen_req,
  input  logic                       clear,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic                       busy,
  output logic                       gen_valid,
  output logic [OUT_W-1:0]           rand_out,
  output logic [$clog2(DEPTH+1)-1:0] seq_count,
  output logic                       seq_full,
  output logic [OUT_W-1:0]           rd_data
);

  import rand_seq_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

`ifdef RAND_SEQ_ZERO_GUARD_EN
  localparam logic [WIDTH-1:0] GUARD = WIDTH'(zero_guard(WIDTH));
`endif

  gen_fsm_t         fsm;
  gen_fsm_t         fsm_next;
  logic [WIDTH-1:0] gen_state;
  logic [WIDTH-1:0] mid_square;
  logic [WIDTH-1:0] next_mid;
  logic [WIDTH-1:0] next_seed;
  logic             sq_start;
  logic             sq_done;
  logic             commit;
  logic [OUT_W-1:0] buffer [DEPTH];

  // seed_load doubles as the squarer kill so an abort leaves nothing pending.
  ms_square_mul #(
    .WIDTH(WIDTH)
  ) u_square (
    .clock      (CLOCK_50),
    .reset      (reset),
    .start      (sq_start),
    .kill       (seed_load),
    .operand    (gen_state),
    .done       (sq_done),
    .mid_square (mid_square)
  );

  assign seq_full = (seq_count == CNT_W'(DEPTH));

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) fsm <= IDLE;
    else       fsm <= fsm_next;
  end

  always_comb begin
    fsm_next = fsm;
    if (seed_load) begin
      fsm_next = IDLE;
    end else begin
      case (fsm)
        IDLE:    if (gen_req && !seq_full) fsm_next = SQUARE;
        SQUARE:  if (sq_done) fsm_next = DONE;
        DONE:    fsm_next = IDLE;
        default: fsm_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (fsm != IDLE);
    sq_start = (fsm == IDLE) && gen_req && !seq_full && !seed_load;
    commit   = (fsm == DONE) && !seed_load;
  end

  // Every path that writes the state register goes through the same guard.
  always_comb begin
    next_mid  = mid_square;
    next_seed = seed;
`ifdef RAND_SEQ_ZERO_GUARD_EN
    if (next_mid == '0)  next_mid  = GUARD;
    if (next_seed == '0) next_seed = GUARD;
`endif
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      gen_state <= DEFAULT_SEED;
      rand_out  <= '0;
      gen_valid <= 1'b0;
      seq_count <= '0;
    end else begin
      gen_valid <= commit;
      if (seed_load) begin
        gen_state <= next_seed;
      end else if (commit) begin
        gen_state <= next_mid;
        rand_out  <= next_mid[OUT_W-1:0];
      end
      if (clear)                    seq_count <= '0;
      else if (commit && !seq_full) seq_count <= seq_count + CNT_W'(1);
    end
  end

  // Contents survive reset and clear; the rd_data mask hides stale entries.
  always_ff @(posedge CLOCK_50) begin
    if (commit && !seq_full) buffer[seq_count[IDX_W-1:0]] <= next_mid[OUT_W-1:0];
  end

  assign rd_data = (CNT_W'(rd_idx) < seq_count) ? buffer[rd_idx] : '0;

endmodule
